// File: rtl/life_run_ctrl_if.sv
// Command and frame handshake bundle between the Life host/display side and life_run_ctrl.
// Both channels transfer on a clock edge where valid and ready are high together; valid, once raised, holds until that edge.
interface life_run_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        frame_valid;
   logic        frame_ready;

   modport master (output cmd_valid, cmd_op, cmd_arg, frame_ready,
                   input  cmd_ready, frame_valid);
   modport slave  (input  cmd_valid, cmd_op, cmd_arg, frame_ready,
                   output cmd_ready, frame_valid);
endinterface

// File: rtl/life_run_ctrl.sv
// Life array sequencer: LFSR seeding, reset/step strobes, frame handshake and generation count.
// Define LIFE_STILL_DETECT_EN to also halt a run when a generation leaves the array unchanged.
module life_run_ctrl #(
   parameter int WIDTH    = 20,
   parameter int HEIGHT   = 20,
   parameter int CELL_NUM = WIDTH * HEIGHT
) (
   input  logic                clock,
   input  logic                reset,
   life_run_ctrl_if.slave      bus,
   input  logic [CELL_NUM-1:0] states,
   output logic [CELL_NUM-1:0] array_init,
   output logic                array_reset,
   output logic                array_step,
   output logic [31:0]         gen_count,
   output logic                busy,
   output logic                done,
   output logic [1:0]          halt_reason,
   output logic                cmd_err,
   output logic [2:0]          state_dbg
);
   localparam int          IDX_W = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
   localparam logic [31:0] TAPS  = 32'h8020_0003;

   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_RUN  = 2'd2;
   localparam logic [1:0] OP_STOP = 2'd3;

   localparam logic [1:0] HALT_COUNT   = 2'd0;
   localparam logic [1:0] HALT_STOP    = 2'd1;
   localparam logic [1:0] HALT_EXTINCT = 2'd2;
   localparam logic [1:0] HALT_STILL   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_PULSE, S_SETTLE, S_SHOW, S_STEP
   } state_t;

   state_t             state;
   logic [31:0]        lfsr;
   logic [31:0]        lfsr_next;
   logic [31:0]        remaining;
   logic [IDX_W-1:0]   idx;
   logic               unbounded;
   logic               from_load;
   logic               stop_pending;
   logic               cmd_fire;
   logic               stop_cmd;
   logic               stop_now;
   logic               still;

   assign bus.cmd_ready = ~reset;
   assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;
   assign stop_cmd      = cmd_fire && (bus.cmd_op == OP_STOP);
   // A STOP arriving in the same cycle as a decision point counts as already pending.
   assign stop_now      = stop_pending | stop_cmd;
   assign busy          = (state != S_IDLE);
   assign state_dbg     = state;
   assign lfsr_next     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

`ifdef LIFE_STILL_DETECT_EN
   logic [CELL_NUM-1:0] prev;
   assign still = (states == prev);
`else
   assign still = 1'b0;
`endif

   // Strobes and frame_valid are registered: each is high during the state after the one that set it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         array_reset     <= 1'b0;
         array_step      <= 1'b0;
         bus.frame_valid <= 1'b0;
         done            <= 1'b0;
         cmd_err         <= 1'b0;
         gen_count       <= 32'd0;
         halt_reason     <= HALT_COUNT;
         array_init      <= '0;
         lfsr            <= 32'd1;
         stop_pending    <= 1'b0;
         idx             <= '0;
         remaining       <= 32'd0;
         unbounded       <= 1'b0;
         from_load       <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
         prev            <= '0;
`endif
      end else begin
         array_reset <= 1'b0;
         array_step  <= 1'b0;
         done        <= 1'b0;
         cmd_err     <= 1'b0;

         if (state != S_IDLE && cmd_fire) begin
            if (stop_cmd)
               stop_pending <= 1'b1;
            else if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_RUN)
               cmd_err <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (cmd_fire && bus.cmd_op == OP_LOAD) begin
                  lfsr      <= (bus.cmd_arg == 32'd0) ? 32'd1 : bus.cmd_arg;
                  idx       <= '0;
                  gen_count <= 32'd0;
                  from_load <= 1'b1;
                  state     <= S_FILL;
               end else if (cmd_fire && bus.cmd_op == OP_RUN) begin
                  remaining <= bus.cmd_arg;
                  unbounded <= (bus.cmd_arg == 32'd0);
                  from_load <= 1'b0;
                  state     <= S_STEP;
               end
            end
            S_FILL: begin
               lfsr            <= lfsr_next;
               array_init[idx] <= lfsr_next[0];
               idx             <= idx + 1'b1;
               if (stop_now) begin
                  stop_pending <= 1'b0;
                  done         <= 1'b1;
                  halt_reason  <= HALT_STOP;
                  state        <= S_IDLE;
               end else if (idx == IDX_W'(CELL_NUM - 1)) begin
                  state <= S_PULSE;
               end
            end
            S_PULSE: begin
               array_reset <= 1'b1;
               state       <= S_SETTLE;
            end
            S_STEP: begin
               array_step <= 1'b1;
               gen_count  <= gen_count + 32'd1;
`ifdef LIFE_STILL_DETECT_EN
               prev       <= states;
`endif
               if (!unbounded)
                  remaining <= remaining - 32'd1;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               bus.frame_valid <= 1'b1;
               state           <= S_SHOW;
            end
            S_SHOW: begin
               if (bus.frame_ready) begin
                  bus.frame_valid <= 1'b0;
                  stop_pending    <= 1'b0;
                  if (from_load) begin
                     done <= 1'b1; halt_reason <= HALT_COUNT; state <= S_IDLE;
                  end else if (stop_now) begin
                     done <= 1'b1; halt_reason <= HALT_STOP; state <= S_IDLE;
                  end else if (states == '0) begin
                     done <= 1'b1; halt_reason <= HALT_EXTINCT; state <= S_IDLE;
                  end else if (still) begin
                     done <= 1'b1; halt_reason <= HALT_STILL; state <= S_IDLE;
                  end else if (!unbounded && remaining == 32'd0) begin
                     done <= 1'b1; halt_reason <= HALT_COUNT; state <= S_IDLE;
                  end else begin
                     state <= S_STEP;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_life_run_ctrl.sv
// Bench for life_run_ctrl: behavioural Life array, LFSR/generation reference model and frame scoreboard.
module tb_life_run_ctrl;
   localparam int WIDTH    = 20;
   localparam int HEIGHT   = 20;
   localparam int CELL_NUM = WIDTH * HEIGHT;
   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_RUN  = 2'd2;
   localparam logic [1:0] OP_STOP = 2'd3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   life_run_ctrl_if bus ();
   logic [CELL_NUM-1:0] states, array_init;
   logic [CELL_NUM-1:0] arr = '0;
   logic                array_reset, array_step, busy, done, cmd_err;
   logic [31:0]         gen_count;
   logic [1:0]          halt_reason;
   logic [2:0]          state_dbg;

   assign states = arr;

   life_run_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clock(clock), .reset(reset), .bus(bus), .states(states),
      .array_init(array_init), .array_reset(array_reset), .array_step(array_step),
      .gen_count(gen_count), .busy(busy), .done(done), .halt_reason(halt_reason),
      .cmd_err(cmd_err), .state_dbg(state_dbg)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int arr_mode = 0;  // 0 real Life, 1 dies on step, 2 never changes
   logic [CELL_NUM-1:0] model_cur = '0;

   int rst_cnt, rst_cyc, fv_first, cur_len, done_cnt, err_cnt, viol;
   int step_q[$];
   int len_q[$];
   logic [CELL_NUM-1:0] got_q[$];
   logic [CELL_NUM-1:0] exp_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [CELL_NUM-1:0] life_next(input logic [CELL_NUM-1:0] s);
      logic [CELL_NUM-1:0] o;
      int n;
      o = '0;
      for (int r = 0; r < HEIGHT; r++)
         for (int c = 0; c < WIDTH; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < HEIGHT &&
                      c + dc >= 0 && c + dc < WIDTH)
                     n += int'(s[(r + dr) * WIDTH + c + dc]);
            o[r * WIDTH + c] = (n == 3) || (n == 2 && s[r * WIDTH + c]);
         end
      return o;
   endfunction

   function automatic logic [CELL_NUM-1:0] stub_next(input logic [CELL_NUM-1:0] s);
      if (arr_mode == 1) return '0;
      if (arr_mode == 2) return s;
      return life_next(s);
   endfunction

   // First `cells` bits the LFSR emits from `seed`, remaining bits zero.
   function automatic logic [CELL_NUM-1:0] lfsr_fill(input logic [31:0] seed, input int cells);
      logic [CELL_NUM-1:0] v;
      logic [31:0] l;
      logic b;
      v = '0;
      l = (seed == 0) ? 32'd1 : seed;
      for (int i = 0; i < cells; i++) begin
         b = l[0];
         l = (l >> 1) ^ (b ? 32'h8020_0003 : 32'h0);
         v[i] = l[0];
      end
      return v;
   endfunction

   // Behavioural Life array reacting to the controller's strobes.
   always @(posedge clock) begin
      if (array_reset) arr <= array_init;
      else if (array_step) arr <= stub_next(arr);
   end

   always @(negedge clock) begin
      if (array_reset) begin rst_cnt++; rst_cyc = cyc; end
      if (array_step) begin
         step_q.push_back(cyc);
         if (bus.frame_valid) viol++;
      end
      if (array_reset && array_step) viol++;
      if (bus.frame_valid) begin
         if (fv_first < 0) fv_first = cyc;
         cur_len++;
         if (bus.frame_ready) begin
            got_q.push_back(states);
            len_q.push_back(cur_len);
            cur_len = 0;
         end
      end
      if (done) done_cnt++;
      if (cmd_err) err_cnt++;
   end

   task automatic clear_mon();
      rst_cnt = 0; rst_cyc = -1; fv_first = -1; cur_len = 0;
      done_cnt = 0; err_cnt = 0; viol = 0;
      step_q.delete(); len_q.delete(); got_q.delete(); exp_q.delete();
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
      tick();
      acc_cyc = cyc;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0;
   endtask

   // Runs cycles until done, driving frame_ready and optional mid-run STOP/LOAD.
   task automatic drive_run(input int budget, input int stall_at, input int stall_len,
                            input bit rnd, input int stop_gen, input int err_gen,
                            output bit timeout);
      int stalled = 0;
      bit stop_sent = 0;
      bit err_sent = 0;
      timeout = 1'b1;
      for (int n = 0; n < budget; n++) begin
         bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0;
         if (bus.frame_valid && got_q.size() == stall_at && stalled < stall_len) begin
            bus.frame_ready = 1'b0; stalled++;
         end else begin
            bus.frame_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (!stop_sent && stop_gen > 0 && array_step && gen_count == 32'(stop_gen)) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = OP_STOP; stop_sent = 1'b1;
         end else if (!err_sent && err_gen > 0 && array_step && gen_count == 32'(err_gen)) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = OP_LOAD; bus.cmd_arg = $urandom; err_sent = 1'b1;
         end
         tick();
         if (done_cnt > 0) begin timeout = 1'b0; break; end
      end
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.frame_ready = 1'b1;
   endtask

   // Reference run: successive generations from `start`, ending on the first halt rule that fires.
   task automatic model_run(input logic [CELL_NUM-1:0] start, input int n, input int stop_gen,
                            output int gens, output logic [1:0] reason);
      logic [CELL_NUM-1:0] cur, prv;
      bit fin = 0;
      cur = start; gens = 0; reason = 2'd0;
      while (!fin && gens < 200) begin
         prv = cur;
         cur = stub_next(cur);
         gens++;
         exp_q.push_back(cur);
         if (gens == stop_gen) begin reason = 2'd1; fin = 1; end
         else if (cur == '0) begin reason = 2'd2; fin = 1; end
`ifdef LIFE_STILL_DETECT_EN
         else if (cur == prv) begin reason = 2'd3; fin = 1; end
`endif
         else if (n != 0 && gens == n) begin reason = 2'd0; fin = 1; end
      end
      model_cur = cur;
   endtask

   task automatic do_load(input logic [31:0] seed);
      bit to;
      clear_mon();
      send_cmd(OP_LOAD, seed);
      drive_run(600, -1, 0, 1'b0, 0, 0, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL load_timeout: no done within 600 cycles"); end
      model_cur = lfsr_fill(seed, CELL_NUM);
   endtask

   task automatic check_run(input string name, input bit to, input int g, input logic [1:0] r);
      bit ok;
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL %s_timeout: no done within budget", name); end
      tests_run++;
      if (gen_count !== 32'(g)) begin tests_failed++; $display("FAIL %s_gen: got %0d want %0d", name, gen_count, g); end
      tests_run++;
      if (halt_reason !== r) begin tests_failed++; $display("FAIL %s_reason: got %0d want %0d", name, halt_reason, r); end
      tests_run++;
      if (done_cnt !== 1) begin tests_failed++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt); end
      tests_run++;
      if (step_q.size() !== g) begin tests_failed++; $display("FAIL %s_steps: got %0d want %0d", name, step_q.size(), g); end
      ok = (got_q.size() == exp_q.size());
      for (int i = 0; ok && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) ok = 0;
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL %s_frames: got %0d frames want %0d, or contents differ", name, got_q.size(), exp_q.size()); end
      tests_run++;
      if (viol !== 0) begin tests_failed++; $display("FAIL %s_overlap: got %0d strobe/frame overlaps want 0", name, viol); end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      tests_run++;
      if (bus.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
      reset = 1'b0;
      tick();
      tests_run++;
      if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_high: got %b want 1", bus.cmd_ready); end
      tests_run++;
      if ({busy, done, cmd_err, array_reset, array_step, bus.frame_valid} !== 6'b0) begin
         tests_failed++; $display("FAIL reset_flags: got %b want 000000", {busy, done, cmd_err, array_reset, array_step, bus.frame_valid});
      end
      tests_run++;
      if (gen_count !== 32'd0 || halt_reason !== 2'd0) begin
         tests_failed++; $display("FAIL reset_counts: got gen %0d reason %0d want 0 0", gen_count, halt_reason);
      end
      tests_run++;
      if (array_init !== '0) begin tests_failed++; $display("FAIL reset_init: got %h want 0", array_init); end
   endtask

   task automatic test_load();
      do_load(32'd0);
      tests_run++;
      if (rst_cnt !== 1 || rst_cyc !== acc_cyc + CELL_NUM + 1) begin
         tests_failed++; $display("FAIL load_pulse: got %0d pulses at +%0d want 1 at +%0d", rst_cnt, rst_cyc - acc_cyc, CELL_NUM + 1);
      end
      tests_run++;
      if (fv_first !== acc_cyc + CELL_NUM + 2) begin
         tests_failed++; $display("FAIL load_frame_time: got +%0d want +%0d", fv_first - acc_cyc, CELL_NUM + 2);
      end
      exp_q.push_back(lfsr_fill(32'd1, CELL_NUM));
      tests_run++;
      if (array_init !== exp_q[0]) begin tests_failed++; $display("FAIL load_init: got %h want %h", array_init, exp_q[0]); end
      check_run("load", 1'b0, 0, 2'd0);
   endtask

   task automatic test_run_count();
      for (int it = 0; it < 2; it++) begin
         logic [31:0] seed;
         int n, g, ok;
         logic [1:0] r;
         bit to;
         seed = (it == 0) ? 32'hACE1 : $urandom;
         n = (it == 0) ? 3 : $urandom_range(2, 6);
         do_load(seed);
         clear_mon();
         model_run(model_cur, n, 0, g, r);
         send_cmd(OP_RUN, 32'(n));
         drive_run(2000, -1, 0, it == 1, 0, 0, to);
         check_run("run_count", to, g, r);
         if (it == 0) begin
            ok = (step_q.size() > 0) && (step_q[0] == acc_cyc + 1);
            for (int i = 1; i < step_q.size(); i++) if (step_q[i] - step_q[i-1] != 3) ok = 0;
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL run_period: got %0d steps not spaced 3 from accept+1 want period 3", step_q.size()); end
         end
      end
   endtask

   task automatic test_stall();
      int g;
      logic [1:0] r;
      bit to;
      do_load($urandom);
      clear_mon();
      model_run(model_cur, 5, 0, g, r);
      send_cmd(OP_RUN, 32'd5);
      drive_run(2000, 1, 10, 1'b0, 0, 0, to);
      check_run("stall", to, g, r);
      if (g >= 3) begin
         tests_run++;
         if (len_q.size() < 2 || len_q[1] !== 11) begin
            tests_failed++; $display("FAIL stall_hold: got %0d valid cycles want 11", (len_q.size() < 2) ? -1 : len_q[1]);
         end
         tests_run++;
         if (step_q.size() < 3 || step_q[2] - step_q[1] !== 13) begin
            tests_failed++; $display("FAIL stall_step_gap: got %0d want 13", (step_q.size() < 3) ? -1 : step_q[2] - step_q[1]);
         end
      end
   endtask

   task automatic test_stop();
      int g;
      logic [1:0] r;
      bit to;
      do_load($urandom);
      clear_mon();
      model_run(model_cur, 0, 7, g, r);
      send_cmd(OP_RUN, 32'd0);
      drive_run(2000, -1, 0, 1'b0, 7, 3, to);
      check_run("stop", to, g, r);
      tests_run++;
      if (err_cnt !== ((g > 3) ? 1 : 0)) begin tests_failed++; $display("FAIL stop_cmd_err: got %0d want %0d", err_cnt, (g > 3) ? 1 : 0); end
   endtask

   task automatic test_stub(input string name, input int mode, input int n);
      int g;
      logic [1:0] r;
      bit to;
      arr_mode = mode;
      do_load($urandom);
      clear_mon();
      model_run(model_cur, n, 0, g, r);
      send_cmd(OP_RUN, 32'(n));
      drive_run(2000, -1, 0, 1'b0, 0, 0, to);
      check_run(name, to, g, r);
      arr_mode = 0;
   endtask

   task automatic test_stop_fill();
      logic [31:0] seed;
      logic [CELL_NUM-1:0] mask;
      bit to;
      seed = $urandom;
      clear_mon();
      send_cmd(OP_LOAD, seed);
      repeat (49) tick();
      send_cmd(OP_STOP, 32'd0);
      drive_run(10, -1, 0, 1'b0, 0, 0, to);
      check_run("stop_fill", to, 0, 2'd1);
      mask = '0;
      for (int i = 0; i < 50; i++) mask[i] = 1'b1;
      tests_run++;
      if ((array_init & mask) !== lfsr_fill(seed, 50)) begin
         tests_failed++; $display("FAIL stop_fill_init: got %h want %h", array_init & mask, lfsr_fill(seed, 50));
      end
      tests_run++;
      if (rst_cnt !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL stop_fill_idle: got %0d pulses busy %b want 0 0", rst_cnt, busy); end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_cmd(OP_LOAD, $urandom);
      repeat (20) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      tests_run++;
      if (busy !== 1'b0 || done_cnt !== 0 || rst_cnt !== 0) begin
         tests_failed++; $display("FAIL reset_mid: got busy %b done %0d pulses %0d want 0 0 0", busy, done_cnt, rst_cnt);
      end
      tests_run++;
      if (array_init !== '0 || gen_count !== 32'd0) begin tests_failed++; $display("FAIL reset_mid_regs: got init %h gen %0d want 0 0", array_init, gen_count); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = 32'd0; bus.frame_ready = 1'b1;
      clear_mon();
      test_reset();
      test_load();
      test_run_count();
      test_stall();
      test_stop();
      test_stub("extinct", 1, 10);
      test_stub("still", 2, 10);
      test_stop_fill();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
